// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer fill arbiter: MCU port map,
// command bit positions and the fill FSM state type.
package fb_pkg;

  localparam logic [7:0] PORT_DIR_Y    = 8'h90;
  localparam logic [7:0] PORT_DIR_X    = 8'h91;
  localparam logic [7:0] PORT_DIR_WR   = 8'h92;
  localparam logic [7:0] PORT_FILL_X0  = 8'h94;
  localparam logic [7:0] PORT_FILL_Y0  = 8'h95;
  localparam logic [7:0] PORT_FILL_X1  = 8'h96;
  localparam logic [7:0] PORT_FILL_Y1  = 8'h97;
  localparam logic [7:0] PORT_FILL_COL = 8'h98;
  localparam logic [7:0] PORT_CMD      = 8'h99;

  localparam int CMD_START = 0;
  localparam int CMD_ABORT = 1;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } fb_state_t;

endpackage

// File: rtl/fb_raster_walker.sv
// Raster walker for the fill engine: steps (cx,cy) across a latched
// rectangle in X-inner order and flags the final pixel of the rectangle.
module fb_raster_walker (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       load,
  input  logic [6:0] load_x0,
  input  logic [5:0] load_y0,
  input  logic [6:0] load_x1,
  input  logic [5:0] load_y1,
  input  logic       step,
  output logic [6:0] cx,
  output logic [5:0] cy,
  output logic       last
);

  logic [6:0] x0_q;
  logic [6:0] x1_q;
  logic [5:0] y1_q;

  // A stalled cycle simply holds the position so the pixel is retried later.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      x0_q <= '0;
      x1_q <= '0;
      y1_q <= '0;
      cx   <= '0;
      cy   <= '0;
    end else if (load) begin
      x0_q <= load_x0;
      x1_q <= load_x1;
      y1_q <= load_y1;
      cx   <= load_x0;
      cy   <= load_y0;
    end else if (step) begin
      if (cx == x1_q) begin
        cx <= x0_q;
        cy <= cy + 6'd1;
      end else begin
        cx <= cx + 7'd1;
      end
    end
  end

  assign last = (cx == x1_q) && (cy == y1_q);

endmodule

// File: rtl/fb_fill_arbiter.sv
// MCU-driven framebuffer writer: direct pixel writes plus a rectangle fill
// engine, with direct writes taking priority and stalling the fill.
module fb_fill_arbiter
  import fb_pkg::*;
#(
  parameter int X_MAX = 79,
  parameter int Y_MAX = 59
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IO_STRB,
  input  logic [7:0]  PORT_ID,
  input  logic [7:0]  OUT_PORT,
  output logic [7:0]  STATUS,
  output logic        BUSY,
  output logic        DONE_IRQ,
  output logic [12:0] FB_WA,
  output logic [7:0]  FB_WD,
  output logic        FB_WE
);

  localparam logic [7:0] X_LIM = 8'(X_MAX);
  localparam logic [7:0] Y_LIM = 8'(Y_MAX);

  fb_state_t  state;
  fb_state_t  next_state;
  logic [6:0] dir_x;
  logic [5:0] dir_y;
  logic [6:0] sh_x0;
  logic [6:0] sh_x1;
  logic [5:0] sh_y0;
  logic [5:0] sh_y1;
  logic [7:0] sh_color;
  logic [7:0] act_color;
  logic       done_flag;
  logic       direct_wr;
  logic       cmd_wr;
  logic       start_req;
  logic       abort_req;
  logic       bad_rect;
  logic       load;
  logic       fill_emit;
  logic [6:0] cx;
  logic [5:0] cy;
  logic       last;
  logic [6:0] clamp_x;
  logic [5:0] clamp_y;

  assign direct_wr = IO_STRB && (PORT_ID == PORT_DIR_WR);
  assign cmd_wr    = IO_STRB && (PORT_ID == PORT_CMD);
  assign start_req = cmd_wr && OUT_PORT[CMD_START];
  assign abort_req = cmd_wr && OUT_PORT[CMD_ABORT];
  assign bad_rect  = (sh_x0 > sh_x1) || (sh_y0 > sh_y1);
  assign clamp_x   = (OUT_PORT > X_LIM) ? X_LIM[6:0] : OUT_PORT[6:0];
  assign clamp_y   = (OUT_PORT > Y_LIM) ? Y_LIM[5:0] : OUT_PORT[5:0];

  // Shadow registers are always writable; the running fill uses its own copies.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      dir_x    <= '0;
      dir_y    <= '0;
      sh_x0    <= '0;
      sh_x1    <= '0;
      sh_y0    <= '0;
      sh_y1    <= '0;
      sh_color <= '0;
    end else if (IO_STRB) begin
      case (PORT_ID)
        PORT_DIR_Y:    dir_y    <= OUT_PORT[5:0];
        PORT_DIR_X:    dir_x    <= OUT_PORT[6:0];
        PORT_FILL_X0:  sh_x0    <= clamp_x;
        PORT_FILL_Y0:  sh_y0    <= clamp_y;
        PORT_FILL_X1:  sh_x1    <= clamp_x;
        PORT_FILL_Y1:  sh_y1    <= clamp_y;
        PORT_FILL_COL: sh_color <= OUT_PORT;
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    fill_emit  = 1'b0;
    case (state)
      IDLE: begin
        if (start_req) begin
          load       = 1'b1;
          next_state = bad_rect ? DONE : FILL;
        end
      end
      FILL: begin
        if (abort_req) begin
          next_state = DONE;
        end else if (!direct_wr) begin
          fill_emit = 1'b1;
          if (last) next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The write port is registered so direct and fill pixels share one path.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      act_color <= '0;
      done_flag <= 1'b0;
      FB_WE     <= 1'b0;
      FB_WA     <= '0;
      FB_WD     <= '0;
    end else begin
      state <= next_state;
      if (load) act_color <= sh_color;
      if (next_state == DONE) done_flag <= 1'b1;
      else if (load)          done_flag <= 1'b0;
      FB_WE <= direct_wr || fill_emit;
      if (direct_wr) begin
        FB_WA <= {dir_y, dir_x};
        FB_WD <= OUT_PORT;
      end else if (fill_emit) begin
        FB_WA <= {cy, cx};
        FB_WD <= act_color;
      end
    end
  end

  fb_raster_walker u_walker (
    .CLK     (CLK),
    .RESET   (RESET),
    .load    (load),
    .load_x0 (sh_x0),
    .load_y0 (sh_y0),
    .load_x1 (sh_x1),
    .load_y1 (sh_y1),
    .step    (fill_emit),
    .cx      (cx),
    .cy      (cy),
    .last    (last)
  );

  assign BUSY     = (state == FILL);
  assign DONE_IRQ = (state == DONE);
  assign STATUS   = {6'b0, done_flag, BUSY};

endmodule

// File: tb/tb_fb_fill_arbiter.sv
// Self-checking bench for fb_fill_arbiter: table-driven direct writes and
// fills, hand-built corner sequences, and randomized fills against a model.
module tb_fb_fill_arbiter;

  localparam int X_MAX = 79;
  localparam int Y_MAX = 59;

  logic        clk = 1'b0;
  logic        RESET;
  logic        IO_STRB;
  logic [7:0]  PORT_ID;
  logic [7:0]  OUT_PORT;
  logic [7:0]  STATUS;
  logic        BUSY;
  logic        DONE_IRQ;
  logic [12:0] FB_WA;
  logic [7:0]  FB_WD;
  logic        FB_WE;

  fb_fill_arbiter #(.X_MAX(X_MAX), .Y_MAX(Y_MAX)) dut (
    .CLK      (clk),
    .RESET    (RESET),
    .IO_STRB  (IO_STRB),
    .PORT_ID  (PORT_ID),
    .OUT_PORT (OUT_PORT),
    .STATUS   (STATUS),
    .BUSY     (BUSY),
    .DONE_IRQ (DONE_IRQ),
    .FB_WA    (FB_WA),
    .FB_WD    (FB_WD),
    .FB_WE    (FB_WE)
  );

  always #5 clk = ~clk;

  // Each write is recorded as {address, data}.
  typedef logic [20:0] wr_t;

  typedef struct {
    logic [7:0]  y;
    logic [7:0]  x;
    logic [7:0]  d;
    logic [12:0] wa;
  } dir_vec_t;

  typedef struct {
    logic [7:0]  x0;
    logic [7:0]  y0;
    logic [7:0]  x1;
    logic [7:0]  y1;
    logic [7:0]  color;
    int          count;
    logic [12:0] last_wa;
  } fill_vec_t;

  wr_t got_q[$];
  wr_t exp_q[$];
  wr_t cmp_q[$];
  wr_t dexp_q[$];
  int  busy_cnt = 0;
  int  irq_cnt = 0;
  int  busy0, irq0, wr0;
  int  checks = 0;
  int  errors = 0;

  dir_vec_t  dir_tab[4];
  fill_vec_t fill_tab[7];

  always @(negedge clk) begin
    if (FB_WE) got_q.push_back({FB_WA, FB_WD});
    if (BUSY) busy_cnt++;
    if (DONE_IRQ) irq_cnt++;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] port, input logic [7:0] data);
    IO_STRB  = 1'b1;
    PORT_ID  = port;
    OUT_PORT = data;
    step(1);
    IO_STRB  = 1'b0;
    PORT_ID  = 8'h00;
    OUT_PORT = 8'h00;
  endtask

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic set_rect(input logic [7:0] x0, input logic [7:0] y0,
                          input logic [7:0] x1, input logic [7:0] y1,
                          input logic [7:0] color);
    apply_stimulus(8'h94, x0);
    apply_stimulus(8'h95, y0);
    apply_stimulus(8'h96, x1);
    apply_stimulus(8'h97, y1);
    apply_stimulus(8'h98, color);
  endtask

  task automatic mark();
    busy0 = busy_cnt;
    irq0  = irq_cnt;
    wr0   = got_q.size();
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (DONE_IRQ !== 1'b1 && n < budget) begin
      step(1);
      n++;
    end
    check_output({name, "_done_seen"}, int'(DONE_IRQ), 1);
  endtask

  // Reference fill: clamp the corners, then list every pixel row by row.
  function automatic void build_fill(int x0, int y0, int x1, int y1, logic [7:0] color);
    int ax0 = (x0 > X_MAX) ? X_MAX : x0;
    int ay0 = (y0 > Y_MAX) ? Y_MAX : y0;
    int ax1 = (x1 > X_MAX) ? X_MAX : x1;
    int ay1 = (y1 > Y_MAX) ? Y_MAX : y1;
    exp_q.delete();
    for (int y = ay0; y <= ay1; y++)
      for (int x = ax0; x <= ax1; x++)
        exp_q.push_back({6'(y), 7'(x), color});
  endfunction

  // mode 0: all writes, 1: fill writes only, 2: direct writes (x beyond X_MAX).
  function automatic void collect(int mode);
    wr_t w;
    cmp_q.delete();
    for (int i = wr0; i < got_q.size(); i++) begin
      w = got_q[i];
      if (mode == 0 || (mode == 1 && int'(w[14:8]) <= X_MAX) ||
          (mode == 2 && int'(w[14:8]) > X_MAX))
        cmp_q.push_back(w);
    end
  endfunction

  task automatic compare_stream(input string name);
    int  bad;
    wr_t g;
    wr_t e;
    bad = -1;
    g = '0;
    e = '0;
    if (cmp_q.size() == exp_q.size())
      for (int i = 0; i < cmp_q.size(); i++)
        if (bad < 0 && cmp_q[i] !== exp_q[i]) bad = i;
    if (bad >= 0) begin
      g = cmp_q[bad];
      e = exp_q[bad];
    end
    checks++;
    if (cmp_q.size() != exp_q.size() || bad >= 0) begin
      errors++;
      $display("[TB] FAIL %s actual %0d writes (idx %0d = 0x%0h) expected %0d writes (0x%0h)",
               name, cmp_q.size(), bad, g, exp_q.size(), e);
    end
  endtask

  initial begin
    int  x0, y0, w, h, k, s;
    logic [7:0] color, dy, dx, dd;
    wr_t lastw;

    RESET = 1'b1;
    IO_STRB = 1'b0;
    PORT_ID = 8'h00;
    OUT_PORT = 8'h00;

    dir_tab[0] = '{8'h05, 8'h07, 8'hAA, {6'd5, 7'd7}};
    dir_tab[1] = '{8'hFF, 8'hFF, 8'h55, {6'h3F, 7'h7F}};
    dir_tab[2] = '{8'h40, 8'h80, 8'h00, {6'd0, 7'd0}};
    dir_tab[3] = '{8'd59, 8'd79, 8'hFF, {6'd59, 7'd79}};

    fill_tab[0] = '{8'd2,  8'd3,  8'd4,  8'd4,  8'hE0, 6,    {6'd4, 7'd4}};
    fill_tab[1] = '{8'd7,  8'd7,  8'd7,  8'd7,  8'h33, 1,    {6'd7, 7'd7}};
    fill_tab[2] = '{8'd0,  8'd0,  8'hFF, 8'hFF, 8'h11, 4800, {6'd59, 7'd79}};
    fill_tab[3] = '{8'd5,  8'd0,  8'd3,  8'd2,  8'h22, 0,    13'd0};
    fill_tab[4] = '{8'd0,  8'd4,  8'd3,  8'd1,  8'h99, 0,    13'd0};
    fill_tab[5] = '{8'd0,  8'd10, 8'd79, 8'd10, 8'h0F, 80,   {6'd10, 7'd79}};
    fill_tab[6] = '{8'd78, 8'd58, 8'h90, 8'hC8, 8'h77, 4,    {6'd59, 7'd79}};

    step(2);
    check_output("reset_status", int'(STATUS), 0);
    check_output("reset_busy", int'(BUSY), 0);
    check_output("reset_irq", int'(DONE_IRQ), 0);
    check_output("reset_we", int'(FB_WE), 0);
    check_output("reset_wa", int'(FB_WA), 0);
    check_output("reset_wd", int'(FB_WD), 0);
    RESET = 1'b0;
    step(1);

    $display("[TB] direct write table");
    foreach (dir_tab[i]) begin
      apply_stimulus(8'h90, dir_tab[i].y);
      apply_stimulus(8'h91, dir_tab[i].x);
      apply_stimulus(8'h92, dir_tab[i].d);
      check_output($sformatf("direct%0d_we", i), int'(FB_WE), 1);
      check_output($sformatf("direct%0d_wa", i), int'(FB_WA), int'(dir_tab[i].wa));
      check_output($sformatf("direct%0d_wd", i), int'(FB_WD), int'(dir_tab[i].d));
      step(1);
      check_output($sformatf("direct%0d_we_drop", i), int'(FB_WE), 0);
    end

    $display("[TB] fill table");
    foreach (fill_tab[i]) begin
      set_rect(fill_tab[i].x0, fill_tab[i].y0, fill_tab[i].x1, fill_tab[i].y1, fill_tab[i].color);
      mark();
      apply_stimulus(8'h99, 8'h01);
      wait_done($sformatf("fill%0d", i), 10000);
      step(2);
      build_fill(fill_tab[i].x0, fill_tab[i].y0, fill_tab[i].x1, fill_tab[i].y1, fill_tab[i].color);
      collect(0);
      check_output($sformatf("fill%0d_count", i), cmp_q.size(), fill_tab[i].count);
      if (fill_tab[i].count > 0 && cmp_q.size() > 0) begin
        lastw = cmp_q[cmp_q.size() - 1];
        check_output($sformatf("fill%0d_last_wa", i), int'(lastw[20:8]), int'(fill_tab[i].last_wa));
      end
      compare_stream($sformatf("fill%0d_stream", i));
      check_output($sformatf("fill%0d_busy", i), busy_cnt - busy0, fill_tab[i].count);
      check_output($sformatf("fill%0d_irq", i), irq_cnt - irq0, 1);
      check_output($sformatf("fill%0d_status", i), int'(STATUS), 2);
    end

    $display("[TB] inverted rectangle pulse");
    set_rect(8'd5, 8'd0, 8'd3, 8'd0, 8'h22);
    apply_stimulus(8'h99, 8'h01);
    check_output("inv_irq_high", int'(DONE_IRQ), 1);
    check_output("inv_busy_low", int'(BUSY), 0);
    step(1);
    check_output("inv_irq_drop", int'(DONE_IRQ), 0);
    check_output("inv_status", int'(STATUS), 2);

    $display("[TB] direct-write priority");
    apply_stimulus(8'h90, 8'd10);
    apply_stimulus(8'h91, 8'd10);
    set_rect(8'd20, 8'd20, 8'd21, 8'd21, 8'h44);
    mark();
    apply_stimulus(8'h99, 8'h01);
    check_output("prio_status_start", int'(STATUS), 1);
    step(2);
    apply_stimulus(8'h92, 8'h1C);
    wait_done("prio", 50);
    step(2);
    exp_q.delete();
    exp_q.push_back({6'd20, 7'd20, 8'h44});
    exp_q.push_back({6'd20, 7'd21, 8'h44});
    exp_q.push_back({6'd10, 7'd10, 8'h1C});
    exp_q.push_back({6'd21, 7'd20, 8'h44});
    exp_q.push_back({6'd21, 7'd21, 8'h44});
    collect(0);
    compare_stream("prio_stream");
    check_output("prio_busy", busy_cnt - busy0, 5);

    $display("[TB] abort and ignored start");
    set_rect(8'd0, 8'd0, 8'd9, 8'd9, 8'h5A);
    mark();
    apply_stimulus(8'h99, 8'h01);
    step(2);
    apply_stimulus(8'h96, 8'd2);
    step(1);
    apply_stimulus(8'h99, 8'h01);
    step(14);
    apply_stimulus(8'h99, 8'h02);
    check_output("abort_irq", int'(DONE_IRQ), 1);
    step(2);
    build_fill(0, 0, 9, 9, 8'h5A);
    while (exp_q.size() > 19) exp_q.pop_back();
    collect(0);
    compare_stream("abort_stream");
    check_output("abort_busy", busy_cnt - busy0, 20);
    check_output("abort_irq_count", irq_cnt - irq0, 1);
    check_output("abort_status", int'(STATUS), 2);

    $display("[TB] reset mid-fill");
    set_rect(8'd0, 8'd0, 8'd9, 8'd9, 8'h66);
    mark();
    apply_stimulus(8'h99, 8'h01);
    step(3);
    RESET = 1'b1;
    step(1);
    RESET = 1'b0;
    check_output("rst_we", int'(FB_WE), 0);
    check_output("rst_busy", int'(BUSY), 0);
    check_output("rst_irq", int'(DONE_IRQ), 0);
    check_output("rst_status", int'(STATUS), 0);
    step(3);
    check_output("rst_writes", got_q.size() - wr0, 3);
    check_output("rst_irq_count", irq_cnt - irq0, 0);
    mark();
    apply_stimulus(8'h99, 8'h03);
    wait_done("rst_recover", 20);
    step(2);
    build_fill(0, 0, 0, 0, 8'h00);
    collect(0);
    compare_stream("rst_recover_stream");

    $display("[TB] randomized fills");
    for (int it = 0; it < 20; it++) begin
      x0 = $urandom_range(0, 30);
      y0 = $urandom_range(0, 20);
      w  = $urandom_range(4, 8);
      h  = $urandom_range(3, 5);
      k  = $urandom_range(0, 3);
      color = 8'($urandom);
      s = 0;
      set_rect(8'(x0), 8'(y0), 8'(x0 + w - 1), 8'(y0 + h - 1), color);
      mark();
      dexp_q.delete();
      apply_stimulus(8'h99, 8'h01);
      for (int j = 0; j < k; j++) begin
        dy = 8'($urandom_range(0, 63));
        dx = 8'($urandom_range(100, 127));
        dd = 8'($urandom);
        if ($urandom_range(0, 1) == 1)
          apply_stimulus(8'(8'h94 + $urandom_range(0, 4)), 8'($urandom));
        apply_stimulus(8'h90, dy);
        apply_stimulus(8'h91, dx);
        if (BUSY === 1'b1) s++;
        apply_stimulus(8'h92, dd);
        dexp_q.push_back({dy[5:0], dx[6:0], dd});
      end
      wait_done($sformatf("rand%0d", it), 200);
      step(2);
      build_fill(x0, y0, x0 + w - 1, y0 + h - 1, color);
      collect(1);
      compare_stream($sformatf("rand%0d_fill", it));
      exp_q = dexp_q;
      collect(2);
      compare_stream($sformatf("rand%0d_direct", it));
      check_output($sformatf("rand%0d_busy", it), busy_cnt - busy0, w * h + s);
      check_output($sformatf("rand%0d_irq", it), irq_cnt - irq0, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
